multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the single-issue MIPS datapath: IFU, GRF, EXT, ALU and DM.
- It walks each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives all datapath select and enable signals per state.
- It handshakes with a variable-latency data memory and counts retired instructions.
- It replaces the purely combinational controller wherever the datapath is multi-cycled.

Parameters:
- RET_W, 32, width of the retired-instruction counter.
- MEM_TO, 15, maximum wait cycles in MEM before mem_err is flagged (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- cmp  in  1  ALU bool_res (equal flag).
- mem_ready  in  1  DM has completed the current access.
- ir_write_enable  out  1  latch the fetched instruction.
- pc_write_enable  out  1  load nPC into PC.
- reg_write_enable  out  1  GRF write strobe.
- mem_write_enable  out  1  DM write strobe.
- mem_req  out  1  DM access request.
- alu_op  out  4  ALU operation select.
- ext_op  out  3  EXT mode select.
- alu_src  out  3  ALU B-operand select.
- nPC_sel  out  3  next-PC select.
- regw_dst  out  3  GRF destination select.
- regw_src  out  3  GRF write-data select.
- width  out  3  DM access width.
- state  out  3  current FSM state.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  one-cycle pulse on DECODE of an unsupported instruction.
- mem_err  out  1  sticky memory-timeout flag.
- retired  out  RET_W  count of completed instructions.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, retired=0, mem_err=0, wait counter=0.
  - All strobes 0; all select outputs 0.
  - A reset asserted mid-instruction aborts it with no write.
- Encodings:
  - State: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
  - nPC_sel: 0=PC+4, 1=branch, 2=j-index, 3=jr.
  - regw_dst: 0=rt, 1=rd, 2=$31.
  - regw_src: 0=alu, 1=mem, 2=imm32, 3=PC+4.
  - alu_src: 0=reg, 1=imm32.
  - ext_op: 0=zero, 1=sign, 2=lui (imm<<16).
  - alu_op: 0=add, 1=sub, 2=or, 3=eq.
  - width: 0=word.
- Output style:
  - Select outputs are combinational from the current state and the opcode/funct.
  - Strobes are high only in the listed cycles; the FSM registers its next state.
- Supported instructions: add, sub, ori, lw, sw, beq, lui, jal, jr, nop (sll 0). Everything else is illegal.
- FETCH: ir_write_enable=1; next state DECODE.
- DECODE:
  - Illegal instruction: illegal=1, pc_write_enable=1 with nPC_sel=0, instr_done=1; next FETCH (treated as nop).
  - jal and jr go directly to WB; all others go to EXEC.
- EXEC:
  - add/sub/ori/lui go to WB.
  - lw/sw go to MEM, with alu_op=add, alu_src=1, ext_op=1.
  - beq: alu_op=eq, pc_write_enable=1, nPC_sel = cmp ? 1 : 0, instr_done=1; next FETCH.
- MEM:
  - mem_req=1 while waiting; mem_write_enable=1 for sw only, held with mem_req.
  - When mem_ready=1: lw goes to WB; sw ends with pc_write_enable=1, instr_done=1, next FETCH.
  - Wait counter increments each cycle without mem_ready. When it reaches MEM_TO: mem_err=1 (sticky) and next state HALT.
  - The wait counter clears on leaving MEM.
- WB:
  - reg_write_enable=1, pc_write_enable=1, instr_done=1; next FETCH.
  - add/sub: regw_dst=1, regw_src=0.
  - ori: regw_dst=0, regw_src=0, ext_op=0, alu_src=1.
  - lui: regw_dst=0, regw_src=2, ext_op=2.
  - lw: regw_dst=0, regw_src=1.
  - jal: regw_dst=2, regw_src=3, nPC_sel=2.
  - jr: reg_write_enable=0, nPC_sel=3.
  - nop: reg_write_enable=0.
- HALT: all strobes 0; left only by reset.
- Latency in cycles:
  - beq=3, jr=3, jal=3.
  - add/sub/ori/lui/nop=4.
  - sw=4+waits, lw=5+waits.
  - illegal=2.
- retired increments on every instr_done, including illegal instructions, and wraps modulo 2^RET_W.
- pc_write_enable asserts exactly once per instruction; reg_write_enable and mem_write_enable never assert together.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state, nPC_sel, regw_dst, regw_src, alu_src, ext_op, alu_op and width encodings;
  - the opcode constants (R=0x00, ori=0x0D, lw=0x23, sw=0x2B, beq=0x04, lui=0x0F, jal=0x03);
  - the funct constants (add=0x20, sub=0x22, jr=0x08).
- One sub-module, instr_decode, performs the combinational opcode/funct classification into an instruction class plus illegal. The FSM, counters and output muxing stay in multicycle_ctrl.

Test Plan:
- Release reset, feed add (op 0x00, funct 0x20) -> FETCH, DECODE, EXEC, WB. In WB: reg_write_enable=1, regw_dst=1, regw_src=0, pc_write_enable=1; retired=1.
- lw (0x23) with mem_ready low for 3 cycles -> mem_req high for 4 cycles, then WB with regw_src=1. Total 8 cycles; retired increments.
- beq (0x04): cmp=1 gives nPC_sel=1 in EXEC; cmp=0 gives nPC_sel=0. Both take 3 cycles with a single pc_write_enable.
- jal (0x03) -> WB reached in cycle 3 with regw_dst=2, regw_src=3, nPC_sel=2. jr (funct 0x08) -> nPC_sel=3, reg_write_enable=0.
- sw (0x2B) with mem_ready held 0 and MEM_TO=15 -> mem_err=1 after 15 wait cycles, state=HALT. The flag stays set until reset=0.
- Cases around reset and illegal opcodes:
  - Opcode 0x3F -> illegal pulse in DECODE and instr_done; next state FETCH.
  - Assert reset during MEM of sw -> outputs clear immediately with no further mem_write_enable; retired=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, datapath
// select values, opcode/funct constants and the decoded instruction class.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    NPC_PC4    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JIDX   = 3'd2,
    NPC_JR     = 3'd3
  } npc_sel_e;

  typedef enum logic [2:0] {
    DST_RT = 3'd0,
    DST_RD = 3'd1,
    DST_RA = 3'd2
  } regw_dst_e;

  typedef enum logic [2:0] {
    SRC_ALU = 3'd0,
    SRC_MEM = 3'd1,
    SRC_IMM = 3'd2,
    SRC_PC4 = 3'd3
  } regw_src_e;

  typedef enum logic [2:0] {
    ALUB_REG = 3'd0,
    ALUB_IMM = 3'd1
  } alu_src_e;

  typedef enum logic [2:0] {
    EXT_ZERO = 3'd0,
    EXT_SIGN = 3'd1,
    EXT_LUI  = 3'd2
  } ext_op_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_OR  = 4'd2,
    ALU_EQ  = 4'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    WIDTH_WORD = 3'd0
  } width_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_JR  = 6'h08;

  typedef enum logic [3:0] {
    IC_NOP,
    IC_ADD,
    IC_SUB,
    IC_ORI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_LUI,
    IC_JAL,
    IC_JR,
    IC_ILLEGAL
  } instr_class_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/funct classifier; anything outside the supported set
// is reported as illegal.
module instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_e cls_o,
  output logic         illegal_o
);

  always_comb begin
    cls_o = IC_ILLEGAL;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_SLL:  cls_o = IC_NOP;
          FN_ADD:  cls_o = IC_ADD;
          FN_SUB:  cls_o = IC_SUB;
          FN_JR:   cls_o = IC_JR;
          default: cls_o = IC_ILLEGAL;
        endcase
      end
      OP_ORI:  cls_o = IC_ORI;
      OP_LW:   cls_o = IC_LW;
      OP_SW:   cls_o = IC_SW;
      OP_BEQ:  cls_o = IC_BEQ;
      OP_LUI:  cls_o = IC_LUI;
      OP_JAL:  cls_o = IC_JAL;
      default: cls_o = IC_ILLEGAL;
    endcase
    illegal_o = (cls_o == IC_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: FETCH/DECODE/EXEC/MEM/WB walk with a
// variable-latency memory handshake, timeout halt and retired counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RET_W  = 32,
  parameter int unsigned MEM_TO = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             cmp,
  input  logic             mem_ready,
  output logic             ir_write_enable,
  output logic             pc_write_enable,
  output logic             reg_write_enable,
  output logic             mem_write_enable,
  output logic             mem_req,
  output logic [3:0]       alu_op,
  output logic [2:0]       ext_op,
  output logic [2:0]       alu_src,
  output logic [2:0]       nPC_sel,
  output logic [2:0]       regw_dst,
  output logic [2:0]       regw_src,
  output logic [2:0]       width,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [RET_W-1:0] retired
);

  localparam logic [7:0] MEM_TO_W = MEM_TO[7:0];

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic [RET_W-1:0] retired_q, retired_d;

  instr_class_e cls;
  logic         dec_illegal;

  instr_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .cls_o    (cls),
    .illegal_o(dec_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    ir_write_enable  = 1'b0;
    pc_write_enable  = 1'b0;
    reg_write_enable = 1'b0;
    mem_write_enable = 1'b0;
    mem_req          = 1'b0;
    instr_done       = 1'b0;
    illegal          = 1'b0;
    alu_op           = ALU_ADD;
    ext_op           = EXT_ZERO;
    alu_src          = ALUB_REG;
    nPC_sel          = NPC_PC4;
    regw_dst         = DST_RT;
    regw_src         = SRC_ALU;
    width            = WIDTH_WORD;
    state_d          = state_q;
    wait_d           = '0;
    mem_err_d        = mem_err_q;

    // Outputs are gated by reset so that FETCH's IR strobe stays low while
    // the controller is held in reset.
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          ir_write_enable = 1'b1;
          state_d         = ST_DECODE;
        end

        ST_DECODE: begin
          if (dec_illegal) begin
            illegal         = 1'b1;
            pc_write_enable = 1'b1;
            instr_done      = 1'b1;
            state_d         = ST_FETCH;
          end else if (cls == IC_JAL || cls == IC_JR) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (cls)
            IC_ADD: state_d = ST_WB;
            IC_SUB: begin
              alu_op  = ALU_SUB;
              state_d = ST_WB;
            end
            IC_ORI: begin
              alu_op  = ALU_OR;
              alu_src = ALUB_IMM;
              state_d = ST_WB;
            end
            IC_LUI: begin
              ext_op  = EXT_LUI;
              state_d = ST_WB;
            end
            IC_NOP: state_d = ST_WB;
            IC_LW, IC_SW: begin
              alu_src = ALUB_IMM;
              ext_op  = EXT_SIGN;
              state_d = ST_MEM;
            end
            IC_BEQ: begin
              alu_op          = ALU_EQ;
              ext_op          = EXT_SIGN;
              pc_write_enable = 1'b1;
              nPC_sel         = cmp ? NPC_BRANCH : NPC_PC4;
              instr_done      = 1'b1;
              state_d         = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end

        ST_MEM: begin
          alu_src          = ALUB_IMM;
          ext_op           = EXT_SIGN;
          mem_req          = 1'b1;
          mem_write_enable = (cls == IC_SW);
          if (mem_ready) begin
            if (cls == IC_LW) begin
              state_d = ST_WB;
            end else begin
              pc_write_enable = 1'b1;
              instr_done      = 1'b1;
              state_d         = ST_FETCH;
            end
          end else if (wait_q + 8'd1 == MEM_TO_W) begin
            mem_err_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end

        ST_WB: begin
          reg_write_enable = 1'b1;
          pc_write_enable  = 1'b1;
          instr_done       = 1'b1;
          state_d          = ST_FETCH;
          case (cls)
            IC_ADD: regw_dst = DST_RD;
            IC_SUB: begin
              regw_dst = DST_RD;
              alu_op   = ALU_SUB;
            end
            IC_ORI: begin
              alu_op  = ALU_OR;
              alu_src = ALUB_IMM;
            end
            IC_LUI: begin
              regw_src = SRC_IMM;
              ext_op   = EXT_LUI;
            end
            IC_LW: regw_src = SRC_MEM;
            IC_JAL: begin
              regw_dst = DST_RA;
              regw_src = SRC_PC4;
              nPC_sel  = NPC_JIDX;
            end
            IC_JR: begin
              reg_write_enable = 1'b0;
              nPC_sel          = NPC_JR;
            end
            default: reg_write_enable = 1'b0;
          endcase
        end

        ST_HALT: state_d = ST_HALT;

        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign retired_d = instr_done ? retired_q + RET_W'(1) : retired_q;

  assign state   = state_q;
  assign mem_err = mem_err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a random
// instruction stream checked against per-instruction expectations.
module tb_multicycle_ctrl;

  localparam int RETW  = 4;
  localparam int MEMTO = 15;

  localparam int K_ADD = 0, K_SUB = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
  localparam int K_LUI = 6, K_JAL = 7, K_JR = 8, K_NOP = 9, K_ILL = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      opcode, funct;
  logic            cmp, mem_ready;
  logic            ir_write_enable, pc_write_enable, reg_write_enable;
  logic            mem_write_enable, mem_req, instr_done, illegal, mem_err;
  logic [3:0]      alu_op;
  logic [2:0]      ext_op, alu_src, nPC_sel, regw_dst, regw_src, width, state;
  logic [RETW-1:0] retired;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned exp_ret = 0;

  multicycle_ctrl #(.RET_W(RETW), .MEM_TO(MEMTO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .cmp(cmp),
    .mem_ready(mem_ready), .ir_write_enable(ir_write_enable),
    .pc_write_enable(pc_write_enable), .reg_write_enable(reg_write_enable),
    .mem_write_enable(mem_write_enable), .mem_req(mem_req), .alu_op(alu_op),
    .ext_op(ext_op), .alu_src(alu_src), .nPC_sel(nPC_sel), .regw_dst(regw_dst),
    .regw_src(regw_src), .width(width), .state(state), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20) return K_ADD;
      if (fn == 6'h22) return K_SUB;
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h00) return K_NOP;
      return K_ILL;
    end
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  function automatic int exp_latency(input int k, input int w);
    case (k)
      K_BEQ, K_JR, K_JAL:               return 3;
      K_ADD, K_SUB, K_ORI, K_LUI, K_NOP: return 4;
      K_SW:                             return 4 + w;
      K_LW:                             return 5 + w;
      default:                          return 2;
    endcase
  endfunction

  // Runs one instruction from FETCH to instr_done; entered just after a negedge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic c,
                           input int w, input string tag);
    int k, cyc, memcnt, n_pc, n_rw, n_mw, n_req, n_ill, n_ir, n_both;
    int e_rw, e_req, e_mw, e_npc, e_st, e_dst, e_src;
    bit done;
    logic [2:0] npc_s, dst_s, src_s, ext_s, asrc_s, st_done;
    logic [3:0] aop_s;
    k = classify(op, fn);
    opcode = op; funct = fn; cmp = c; mem_ready = 1'b0;
    cyc = 0; memcnt = 0; n_pc = 0; n_rw = 0; n_mw = 0; n_req = 0; n_ill = 0;
    n_ir = 0; n_both = 0; done = 1'b0;
    npc_s = '0; dst_s = '0; src_s = '0; ext_s = '0; asrc_s = '0; aop_s = '0; st_done = '0;
    #1;
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++; $display("FAIL %s start_state: got %0d want 0", tag, state);
    end
    while (!done && cyc < 64) begin
      if (mem_req) begin
        mem_ready = (memcnt == w);
        memcnt++;
      end else mem_ready = 1'b0;
      #1;
      cyc++;
      if (pc_write_enable) begin n_pc++; npc_s = nPC_sel; aop_s = alu_op; end
      if (reg_write_enable) begin
        n_rw++; dst_s = regw_dst; src_s = regw_src; ext_s = ext_op; asrc_s = alu_src;
      end
      if (mem_write_enable) n_mw++;
      if (mem_req) n_req++;
      if (illegal) n_ill++;
      if (ir_write_enable) n_ir++;
      if (reg_write_enable && mem_write_enable) n_both++;
      if (instr_done) begin done = 1'b1; st_done = state; end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    if (done) exp_ret = (exp_ret + 1) % (1 << RETW);

    e_rw  = (k == K_ADD || k == K_SUB || k == K_ORI || k == K_LUI || k == K_LW || k == K_JAL) ? 1 : 0;
    e_req = (k == K_LW || k == K_SW) ? w + 1 : 0;
    e_mw  = (k == K_SW) ? w + 1 : 0;
    e_npc = (k == K_BEQ) ? (c ? 1 : 0) : (k == K_JAL) ? 2 : (k == K_JR) ? 3 : 0;
    e_st  = (k == K_ILL) ? 1 : (k == K_BEQ) ? 2 : (k == K_SW) ? 3 : 4;
    e_dst = (k == K_ADD || k == K_SUB) ? 1 : (k == K_JAL) ? 2 : 0;
    e_src = (k == K_LW) ? 1 : (k == K_LUI) ? 2 : (k == K_JAL) ? 3 : 0;

    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL %s done_timeout: got no instr_done within 64 cycles", tag); end
    n_cmp++;
    if (cyc != exp_latency(k, w)) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_latency(k, w));
    end
    n_cmp++;
    if (n_pc != 1) begin n_bad++; $display("FAIL %s pc_we_count: got %0d want 1", tag, n_pc); end
    n_cmp++;
    if (n_rw != e_rw) begin n_bad++; $display("FAIL %s reg_we_count: got %0d want %0d", tag, n_rw, e_rw); end
    n_cmp++;
    if (n_mw != e_mw) begin n_bad++; $display("FAIL %s mem_we_count: got %0d want %0d", tag, n_mw, e_mw); end
    n_cmp++;
    if (n_req != e_req) begin n_bad++; $display("FAIL %s mem_req_count: got %0d want %0d", tag, n_req, e_req); end
    n_cmp++;
    if (n_ill != ((k == K_ILL) ? 1 : 0)) begin
      n_bad++; $display("FAIL %s illegal_count: got %0d want %0d", tag, n_ill, (k == K_ILL) ? 1 : 0);
    end
    n_cmp++;
    if (n_ir != 1) begin n_bad++; $display("FAIL %s ir_we_count: got %0d want 1", tag, n_ir); end
    n_cmp++;
    if (n_both != 0) begin n_bad++; $display("FAIL %s reg_mem_overlap: got %0d want 0", tag, n_both); end
    n_cmp++;
    if (int'(npc_s) != e_npc) begin n_bad++; $display("FAIL %s nPC_sel: got %0d want %0d", tag, npc_s, e_npc); end
    n_cmp++;
    if (int'(st_done) != e_st) begin n_bad++; $display("FAIL %s done_state: got %0d want %0d", tag, st_done, e_st); end
    n_cmp++;
    if (int'(retired) != exp_ret) begin n_bad++; $display("FAIL %s retired: got %0d want %0d", tag, retired, exp_ret); end
    if (e_rw == 1) begin
      n_cmp++;
      if (int'(dst_s) != e_dst) begin n_bad++; $display("FAIL %s regw_dst: got %0d want %0d", tag, dst_s, e_dst); end
      n_cmp++;
      if (int'(src_s) != e_src) begin n_bad++; $display("FAIL %s regw_src: got %0d want %0d", tag, src_s, e_src); end
    end
    if (k == K_ORI) begin
      n_cmp++;
      if (ext_s !== 3'd0 || asrc_s !== 3'd1) begin
        n_bad++; $display("FAIL %s ori_ext_alusrc: got %0d/%0d want 0/1", tag, ext_s, asrc_s);
      end
    end
    if (k == K_LUI) begin
      n_cmp++;
      if (ext_s !== 3'd2) begin n_bad++; $display("FAIL %s lui_ext: got %0d want 2", tag, ext_s); end
    end
    if (k == K_BEQ) begin
      n_cmp++;
      if (aop_s !== 4'd3) begin n_bad++; $display("FAIL %s beq_alu_op: got %0d want 3", tag, aop_s); end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (state !== 3'd0 || retired !== '0 || mem_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_regs: got state=%0d retired=%0d mem_err=%0b want 0/0/0", state, retired, mem_err);
    end
    n_cmp++;
    if ({ir_write_enable, pc_write_enable, reg_write_enable, mem_write_enable,
         mem_req, instr_done, illegal} !== 7'd0) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 0000000", {ir_write_enable, pc_write_enable,
        reg_write_enable, mem_write_enable, mem_req, instr_done, illegal});
    end
    n_cmp++;
    if ({alu_op, ext_op, alu_src, nPC_sel, regw_dst, regw_src, width} !== 22'd0) begin
      n_bad++; $display("FAIL reset_selects: got %h want 0",
        {alu_op, ext_op, alu_src, nPC_sel, regw_dst, regw_src, width});
    end
    @(negedge clk);
    reset = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_add();
    run_instr(6'h00, 6'h20, 1'b0, 0, "add");
  endtask

  task automatic test_lw_wait();
    run_instr(6'h23, 6'h00, 1'b0, 3, "lw_wait3");
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h15, 1'b1, 0, "beq_taken");
    run_instr(6'h04, 6'h15, 1'b0, 0, "beq_not_taken");
  endtask

  task automatic test_jumps();
    run_instr(6'h03, 6'h2A, 1'b0, 0, "jal");
    run_instr(6'h00, 6'h08, 1'b0, 0, "jr");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h00, 1'b0, 0, "illegal_3f");
    run_instr(6'h00, 6'h21, 1'b0, 0, "illegal_addu");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [11];
    logic [5:0] fns [11];
    int idx;
    ops = '{6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03, 6'h00, 6'h00, 6'h08};
    fns = '{6'h20, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00};
    for (int i = 0; i < 40; i++) begin
      logic [5:0] fn;
      idx = int'($urandom_range(0, 10));
      fn = (ops[idx] == 6'h00) ? fns[idx] : 6'($urandom);
      run_instr(ops[idx], fn, 1'($urandom), int'($urandom_range(0, 4)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_timeout();
    int cyc, n_req, n_pc, n_done, n_early, n_str;
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b0;
    cyc = 0; n_req = 0; n_pc = 0; n_done = 0; n_early = 0; n_str = 0;
    #1;
    while (state !== 3'd5 && cyc < 100) begin
      if (mem_req) n_req++;
      if (pc_write_enable) n_pc++;
      if (instr_done) n_done++;
      if (mem_err) n_early++;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (state !== 3'd5) begin n_bad++; $display("FAIL timeout_halt: got state %0d want 5", state); end
    n_cmp++;
    if (n_req != MEMTO) begin n_bad++; $display("FAIL timeout_waits: got %0d want %0d", n_req, MEMTO); end
    n_cmp++;
    if (mem_err !== 1'b1 || n_early != 0) begin
      n_bad++; $display("FAIL timeout_mem_err: got %0b early=%0d want 1 early=0", mem_err, n_early);
    end
    n_cmp++;
    if (n_pc != 0 || n_done != 0) begin
      n_bad++; $display("FAIL timeout_no_retire: got pc=%0d done=%0d want 0/0", n_pc, n_done);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (state !== 3'd5 || mem_err !== 1'b1 || {ir_write_enable, pc_write_enable, reg_write_enable,
          mem_write_enable, mem_req, instr_done} !== 6'd0) n_str++;
    end
    n_cmp++;
    if (n_str != 0) begin n_bad++; $display("FAIL halt_sticky: got %0d bad cycles want 0", n_str); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_err !== 1'b0 || state !== 3'd0 || retired !== '0) begin
      n_bad++; $display("FAIL halt_reset: got mem_err=%0b state=%0d retired=%0d want 0/0/0", mem_err, state, retired);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_ret = 0;
  endtask

  task automatic test_reset_mid_mem();
    int cyc;
    run_instr(6'h00, 6'h20, 1'b0, 0, "pre_abort_add");
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b0;
    cyc = 0;
    #1;
    while (!mem_req && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (mem_req !== 1'b1 || mem_write_enable !== 1'b1) begin
      n_bad++; $display("FAIL abort_reach_mem: got req=%0b we=%0b want 1/1", mem_req, mem_write_enable);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_write_enable !== 1'b0 || mem_req !== 1'b0 || state !== 3'd0 || retired !== '0) begin
      n_bad++; $display("FAIL abort_clear: got we=%0b req=%0b state=%0d retired=%0d want 0/0/0/0",
        mem_write_enable, mem_req, state, retired);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (mem_write_enable !== 1'b0 || ir_write_enable !== 1'b0) begin
      n_bad++; $display("FAIL abort_hold: got we=%0b ir=%0b want 0/0", mem_write_enable, ir_write_enable);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_ret = 0;
    run_instr(6'h0D, 6'h00, 1'b0, 0, "post_abort_ori");
  endtask

  initial begin
    reset = 1'b0; opcode = '0; funct = '0; cmp = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_illegal();
    run_instr(6'h0F, 6'h00, 1'b0, 0, "lui");
    run_instr(6'h00, 6'h00, 1'b0, 0, "nop");
    run_instr(6'h2B, 6'h00, 1'b0, 2, "sw_wait2");
    test_back_to_back();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
